// File: rtl/mem_responder_pkg.sv
// Shared encodings, default sizing and helpers for the
// memory responder and its storage array.
package mem_responder_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RESP    = 3'd2
   } state_t;

   localparam int DEF_DW     = 32;
   localparam int DEF_AW     = 6;
   localparam int DEF_DEPTH  = 64;
   localparam int DEF_RD_LAT = 2;

   function automatic logic addr_ok(
      input int unsigned addr,
      input int unsigned depth
   );
      return addr < depth;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read,
// whole array cleared by reset.
module mem_array
   import mem_responder_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we && addr_ok(32'(waddr), DEPTH)) begin
         mem[waddr] <= wdata;
      end
   end

   // Holes above DEPTH read as zero.
   assign rdata = addr_ok(32'(raddr), DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: valid/ready request,
// fixed read latency, held response until consumed.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int AW     = DEF_AW,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          req_ready,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   input  logic          rsp_ready,
   output logic [2:0]    curstate
);

   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;
   logic          accept;
   logic          acc_ok;
   logic          rd_ok;
   logic          cnt_zero;
   logic          mem_we;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign curstate  = state;
   assign accept    = req_valid && req_ready;
   assign acc_ok    = addr_ok(32'(req_addr), DEPTH);
   assign rd_ok     = addr_ok(32'(addr_q), DEPTH);
   assign cnt_zero  = (cnt == '0);
   assign mem_we    = accept && req_we;
   // Single-cycle reads look up the live address in IDLE.
   assign raddr     = (state == IDLE) ? req_addr : addr_q;

   mem_array #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .waddr (req_addr),
      .wdata (req_wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (req_we || RD_LAT == 1) state_nxt = RESP;
               else                       state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: if (cnt_zero) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         addr_q    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  addr_q <= req_addr;
                  if (req_we) begin
                     rsp_rdata <= acc_ok ? req_wdata : '0;
                     rsp_err   <= !acc_ok;
                  end else begin
                     cnt <= CW'(RD_LAT - 1);
                     if (RD_LAT == 1) begin
                        rsp_rdata <= rdata;
                        rsp_err   <= !acc_ok;
                     end
                  end
               end
            end
            RD_WAIT: begin
               if (cnt_zero) begin
                  rsp_rdata <= rdata;
                  rsp_err   <= !rd_ok;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and random checks of mem_responder (DEPTH 64 and 48
// side by side) against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_responder;

   localparam int DW     = 32;
   localparam int AW     = 6;
   localparam int RD_LAT = 2;
   localparam int D64    = 64;
   localparam int D48    = 48;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we    = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_ready = 1'b0;

   logic          rdy_a, vld_a, err_a;
   logic          rdy_b, vld_b, err_b;
   logic [DW-1:0] rd_a, rd_b;
   logic [2:0]    st_a, st_b;

   int tests = 0;
   int fails = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   mem_responder #(
      .DW(DW), .AW(AW), .DEPTH(D64), .RD_LAT(RD_LAT)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(rdy_a), .rsp_valid(vld_a),
      .rsp_rdata(rd_a), .rsp_err(err_a),
      .rsp_ready(rsp_ready), .curstate(st_a)
   );

   mem_responder #(
      .DW(DW), .AW(AW), .DEPTH(D48), .RD_LAT(RD_LAT)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(rdy_b), .rsp_valid(vld_b),
      .rsp_rdata(rd_b), .rsp_err(err_b),
      .rsp_ready(rsp_ready), .curstate(st_b)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask

   // Model: one outstanding transaction, response becomes
   // visible vedge edges after start, data fixed at acceptance.
   logic [DW-1:0] m64 [D64];
   logic [DW-1:0] m48 [D48];
   bit            busy = 1'b0;
   int            cyc = 0;
   int            vedge = 0;
   logic [DW-1:0] p64 = '0, p48 = '0, e64 = '0, e48 = '0;
   bit            pe64 = 0, pe48 = 0, ee64 = 0, ee48 = 0;

   task automatic model_reset();
      for (int i = 0; i < D64; i++) m64[i] = '0;
      for (int i = 0; i < D48; i++) m48[i] = '0;
      busy = 1'b0;
      e64 = '0; e48 = '0; ee64 = 1'b0; ee48 = 1'b0;
   endtask

   initial begin
      int a;
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            cyc++;
            if (busy && cyc > vedge && rsp_ready) begin
               busy = 1'b0;
            end else if (!busy && req_valid) begin
               a = int'(req_addr);
               if (req_we) begin
                  m64[a] = req_wdata;
                  p64 = req_wdata; pe64 = 1'b0;
                  if (a < D48) begin
                     m48[a] = req_wdata;
                     p48 = req_wdata; pe48 = 1'b0;
                  end else begin
                     p48 = '0; pe48 = 1'b1;
                  end
               end else begin
                  p64 = m64[a]; pe64 = 1'b0;
                  if (a < D48) begin
                     p48 = m48[a]; pe48 = 1'b0;
                  end else begin
                     p48 = '0; pe48 = 1'b1;
                  end
               end
               busy = 1'b1;
               vedge = cyc + (req_we ? 0 : RD_LAT);
            end
            if (busy && cyc == vedge) begin
               e64 = p64; ee64 = pe64;
               e48 = p48; ee48 = pe48;
            end
         end
      end
   end

   initial begin
      logic [2:0] est;
      bit         evld;
      wait (started);
      forever begin
         @(negedge clk);
         evld = busy && cyc >= vedge;
         est  = !busy ? 3'd0 : (cyc < vedge ? 3'd1 : 3'd2);
         chk("ready_a", rdy_a, !busy);
         chk("ready_b", rdy_b, !busy);
         chk("valid_a", vld_a, evld);
         chk("valid_b", vld_b, evld);
         chk("state_a", st_a, est);
         chk("state_b", st_b, est);
         chk("rdata_a", rd_a, e64);
         chk("rdata_b", rd_b, e48);
         chk("err_a", err_a, ee64);
         chk("err_b", err_b, ee48);
      end
   end

   int            lat;
   logic [DW-1:0] r_a, r_b;
   logic          e_a, e_b;

   // Issue one request, hold rsp_ready low for `hold` cycles
   // once the response shows, then consume it.
   task automatic do_req(input bit we, input int addr,
                         input logic [DW-1:0] d, input int hold,
                         input logic [DW-1:0] hexp);
      int n;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = AW'(addr);
      req_wdata = d;
      rsp_ready = 1'b0;
      n = 0;
      while (!rdy_a && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout("accept");
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!vld_a && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 50) timeout("response");
      r_a = rd_a; e_a = err_a;
      r_b = rd_b; e_b = err_b;
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", vld_a, 1'b1);
         chk("hold_rdata", rd_a, hexp);
         chk("hold_ready", rdy_a, 1'b0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("idle_after", st_a, 3'd0);
   endtask

   initial begin
      logic [DW-1:0] last_w;
      int            n;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      started = 1'b1;
      chk("rst_ready", rdy_a, 1'b1);
      chk("rst_state", st_a, 3'd0);

      do_req(1'b0, 5, '0, 0, '0);
      chk("rd5_lat", lat, 2);
      chk("rd5_data", r_a, 32'h0);
      chk("rd5_err", e_a, 1'b0);

      do_req(1'b1, 12, 32'hDEAD_BEEF, 0, '0);
      chk("wr12_lat", lat, 0);
      chk("wr12_echo", r_a, 32'hDEAD_BEEF);
      do_req(1'b0, 12, '0, 0, '0);
      chk("rd12_a", r_a, 32'hDEAD_BEEF);
      chk("rd12_b", r_b, 32'hDEAD_BEEF);

      do_req(1'b0, 12, '0, 5, 32'hDEAD_BEEF);

      do_req(1'b1, 50, 32'h1234, 0, '0);
      chk("wr50_err_b", e_b, 1'b1);
      chk("wr50_data_b", r_b, 32'h0);
      chk("wr50_err_a", e_a, 1'b0);
      for (int a = 0; a < 64; a++) begin
         do_req(1'b0, a, '0, 0, '0);
         if (a == 12) chk("sweep12_b", r_b, 32'hDEAD_BEEF);
         if (a == 50) begin
            chk("sweep50_a", r_a, 32'h1234);
            chk("sweep50_b", r_b, 32'h0);
            chk("sweep50_err_b", e_b, 1'b1);
         end
      end

      req_valid = 1'b1;
      rsp_ready = 1'b1;
      last_w = '0;
      for (int i = 0; i < 10; i++) begin
         req_we   = (i % 2 == 0);
         req_addr = AW'(63);
         req_wdata = $urandom;
         if (req_we) last_w = req_wdata;
         n = 0;
         while (!rdy_a && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) timeout("b2b_accept");
         @(negedge clk);
      end
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      rsp_ready = 1'b0;
      do_req(1'b0, 63, '0, 0, '0);
      chk("b2b_last", r_a, last_w);

      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = AW'(12);
      @(negedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_state", st_a, 3'd0);
      chk("abort_valid", vld_a, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_quiet", vld_a, 1'b0);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);
      do_req(1'b0, 12, '0, 0, '0);
      chk("post_rst_a", r_a, 32'h0);
      chk("post_rst_b", r_b, 32'h0);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         req_valid = ($urandom_range(0, 2) != 0);
         req_we    = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 2))
            0:       req_addr = AW'($urandom_range(0, 7));
            1:       req_addr = AW'($urandom_range(44, 52));
            default: req_addr = AW'($urandom_range(0, 63));
         endcase
         req_wdata = $urandom;
         rsp_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (6) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
